// File: rtl/fm_dump_pkg.sv
// Shared constants for the FM sample-dump capture block: state encodings,
// CTRL command codes, register addresses and the receive-mode code.
package fm_dump_pkg;

  // One-hot state codes. The status word reports them unchanged in bits 31:28.
  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_CAPTURE = 4'b0010;
  localparam logic [3:0] ST_FULL    = 4'b0100;
  localparam logic [3:0] ST_READ    = 4'b1000;

  localparam logic [2:0] CMD_CAPTURE = 3'b001;
  localparam logic [2:0] CMD_READ    = 3'b010;
  localparam logic [2:0] CMD_RELEASE = 3'b100;

  localparam int unsigned CTRL_ADDR   = 32'h004;
  localparam int unsigned STATUS_ADDR = 32'h005;

  localparam logic [3:0] RCEV = 4'b0010;

  typedef struct packed {
    logic [7:0] dec_m1;
    logic [3:0] ch_sel;
    logic       rsvd;
    logic [2:0] cmd;
  } ctrl_t;

endpackage

// File: rtl/fm_dump_ram.sv
// Capture buffer: simple dual-port RAM with one write port and one
// registered, enabled read port. Contents are not reset.
module fm_dump_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    // Output holds between reads, so the top can reuse it as held read data.
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fm_dump_capture.sv
// Captures decimated samples of one selected channel into a buffer while the
// radio is receiving, then exposes the buffer and a status word for readout.
//
// state   | meaning
// IDLE    | no capture in progress
// CAPTURE | storing every (dec_m1+1)-th strobed sample
// FULL    | buffer complete, waiting for READ
// READ    | buffer readable through rdaddr
module fm_dump_capture
  import fm_dump_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                         clk,
  input  logic                         RSTn,
  input  logic [ADDR_WIDTH-1:0]        wraddr,
  input  logic [31:0]                  wdata,
  input  logic [3:0]                   wea,
  input  logic [ADDR_WIDTH-1:0]        rdaddr,
  input  logic [3:0]                   FM_HW_state,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         sample_valid,
  output logic [31:0]                  rdata,
  output logic                         Dump_Done_Interrupt,
  output logic                         busy
);

  logic [3:0]            r_state;
  logic [DEPTH_LOG2:0]   r_wr_ptr;
  logic [7:0]            r_dec_cnt;
  logic [7:0]            r_dec_m1;
  logic [3:0]            r_ch_sel;
  logic [31:0]           r_rdata;
  logic                  r_use_ram;
  logic                  r_irq;

  ctrl_t                 w_ctrl;
  logic                  w_rcev, w_ctrl_wr, w_cmd_cap, w_cmd_rd, w_cmd_rel;
  logic                  w_store, w_last, w_mem_rd, w_stat_rd;
  logic [DATA_WIDTH-1:0] w_sample, w_ram_q;
  logic [31:0]           w_status;
  logic                  w_unused;

  assign w_ctrl    = ctrl_t'(wdata[15:0]);
  assign w_rcev    = (FM_HW_state == RCEV);
  assign w_ctrl_wr = (wea == 4'hF) && (wraddr == ADDR_WIDTH'(CTRL_ADDR)) && w_rcev;
  assign w_cmd_cap = w_ctrl_wr && (w_ctrl.cmd == CMD_CAPTURE);
  assign w_cmd_rel = w_ctrl_wr && (w_ctrl.cmd == CMD_RELEASE);
  assign w_cmd_rd  = w_ctrl_wr && (w_ctrl.cmd == CMD_READ) && (r_state == ST_FULL);
  // A command landing on a strobe cycle wins; that sample is not stored.
  assign w_store   = (r_state == ST_CAPTURE) && w_rcev && sample_valid &&
                     (r_dec_cnt == 8'd0) && !w_cmd_cap && !w_cmd_rel;
  assign w_last    = (r_wr_ptr[DEPTH_LOG2-1:0] == {DEPTH_LOG2{1'b1}});
  assign w_mem_rd  = rdaddr[ADDR_WIDTH-1] && (r_state == ST_READ);
  assign w_stat_rd = (rdaddr == ADDR_WIDTH'(STATUS_ADDR));
  assign w_unused  = &{1'b0, wdata[31:16], w_ctrl.rsvd};

  // Out-of-range channel selects fall back to channel 0.
  always_comb begin
    w_sample = ch_data[DATA_WIDTH-1:0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (r_ch_sel == 4'(k)) w_sample = ch_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_status                 = '0;
    w_status[31:28]          = r_state;
    w_status[DEPTH_LOG2:0]   = r_wr_ptr;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_wr_ptr  <= '0;
      r_dec_cnt <= '0;
      r_dec_m1  <= '0;
      r_ch_sel  <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      if (w_cmd_cap) begin
        r_state   <= ST_CAPTURE;
        r_ch_sel  <= w_ctrl.ch_sel;
        r_dec_m1  <= w_ctrl.dec_m1;
        r_wr_ptr  <= '0;
        r_dec_cnt <= '0;
      end else if (w_cmd_rel) begin
        r_state <= ST_IDLE;
      end else if (w_cmd_rd) begin
        r_state <= ST_READ;
      end else if (r_state == ST_CAPTURE) begin
        if (!w_rcev) begin
          r_state <= ST_IDLE;
        end else if (sample_valid) begin
          if (r_dec_cnt == 8'd0) begin
            r_wr_ptr  <= r_wr_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
            r_dec_cnt <= r_dec_m1;
            if (w_last) begin
              r_state <= ST_FULL;
              r_irq   <= 1'b1;
            end
          end else begin
            r_dec_cnt <= r_dec_cnt - 8'd1;
          end
        end
      end
    end
  end

  // Memory reads are served straight from the RAM's registered port; status
  // reads land in r_rdata. Either source holds until the next qualifying read.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_rdata   <= '0;
      r_use_ram <= 1'b0;
    end else if (w_mem_rd) begin
      r_use_ram <= 1'b1;
    end else if (w_stat_rd) begin
      r_rdata   <= w_status;
      r_use_ram <= 1'b0;
    end
  end

  fm_dump_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_store),
    .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
    .i_wdata (w_sample),
    .i_re    (w_mem_rd),
    .i_raddr (rdaddr[DEPTH_LOG2-1:0]),
    .o_rdata (w_ram_q)
  );

  assign rdata               = r_use_ram ? 32'(w_ram_q) : r_rdata;
  assign Dump_Done_Interrupt = r_irq;
  assign busy                = (r_state == ST_CAPTURE);

endmodule
